// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter (and any future RX-side
// dispatcher that reuses the round-robin picker).
//   NREQ_DEFAULT : default number of byte-stream requesters
//   BYTE_W       : width of one UART byte lane
//   state_t      : arbiter FSM state encoding
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int BYTE_W       = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        HOLD    = 3'd4
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority pick: returns the first set bit of req
// at or after position ptr, wrapping modulo NREQ.
// Ports:
//   req   in  NREQ  request vector
//   ptr   in  IDXW  highest-priority position (must be < NREQ)
//   idx   out IDXW  selected index (0 when valid is low)
//   valid out 1     at least one request is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] idx,
    output logic            valid
);

    // rot[j] is the request sitting j places after ptr; pos[j] is its index.
    logic [NREQ-1:0] rot;
    logic [IDXW-1:0] pos [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [IDXW:0] sum;
            assign sum     = {1'b0, ptr} + (IDXW+1)'(gi);
            assign pos[gi] = (sum >= (IDXW+1)'(NREQ)) ? IDXW'(sum - (IDXW+1)'(NREQ))
                                                      : sum[IDXW-1:0];
            assign rot[gi] = req[pos[gi]];
        end
    endgenerate

    // Scan from the far end so the nearest set position wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                idx   = pos[j];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one UART transmitter among NREQ byte-stream
// requesters. A requester keeps the UART for a whole packet; the grant moves
// on only after the byte flagged last has been fully serialised.
// Ports:
//   clock, reset_n     clock and asynchronous active-low reset
//   req/last   [NREQ]  per-requester byte valid / end-of-packet flag
//   data  [8*NREQ]     flattened byte lanes, lane k = data[8k+7:8k]
//   ack        [NREQ]  one-cycle pulse when lane k's byte is loaded
//   grant      [NREQ]  one-hot UART owner, held for the whole packet
//   busy               a packet is in progress
//   uart_txen/uart_din load strobe and byte to the UART
//   uart_txready       UART idle indication
// All outputs are registered: they are computed from the next state.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        last,
    input  logic [BYTE_W*NREQ-1:0] data,
    output logic [NREQ-1:0]        ack,
    output logic [NREQ-1:0]        grant,
    output logic                   busy,
    output logic                   uart_txen,
    output logic [BYTE_W-1:0]      uart_din,
    input  logic                   uart_txready
);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic [IDXW-1:0]   ptr_q,   ptr_d;
    logic              eop_q,   eop_d;
    logic [NREQ-1:0]   ack_q,   ack_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              busy_q,  busy_d;
    logic              txen_q,  txen_d;
    logic [BYTE_W-1:0] din_q,   din_d;

    logic [IDXW-1:0]   pick_idx;
    logic              pick_valid;
    logic [BYTE_W-1:0] lane [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign lane[gi] = data[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        eop_d   = eop_q;
        ack_d   = '0;
        grant_d = '0;
        busy_d  = 1'b0;
        txen_d  = 1'b0;
        din_d   = din_q;

        case (state_q)
            IDLE: begin
                // The txready gate also covers a byte still shifting out
                // after a mid-packet reset.
                if (uart_txready && pick_valid) begin
                    owner_d = pick_idx;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = WAIT_LO;
            WAIT_LO: begin
                if (!uart_txready) state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (uart_txready) begin
                    if (eop_q) begin
                        // The finished requester drops to lowest priority.
                        ptr_d   = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + IDXW'(1);
                        state_d = IDLE;
                    end else if (req[owner_q]) begin
                        state_d = LOAD;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (req[owner_q]) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        if (busy_d) grant_d[owner_d] = 1'b1;

        // data/last of the owner are stable until its ack, so sampling them
        // on entry to LOAD is equivalent to sampling them during LOAD.
        if (state_d == LOAD) begin
            txen_d         = 1'b1;
            ack_d[owner_d] = 1'b1;
            din_d          = lane[owner_d];
            eop_d          = last[owner_d];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            eop_q   <= 1'b0;
            ack_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            txen_q  <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            eop_q   <= eop_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            txen_q  <= txen_d;
            din_q   <= din_d;
        end
    end

    assign ack       = ack_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign uart_txen = txen_q;
    assign uart_din  = din_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Testbench for uart_tx_arbiter. A behavioural UART (txready drops the cycle
// after txen, rises after a byte time) and per-requester packet queues drive
// the DUT. Expected transmit order is predicted from the packet queues with
// the round-robin rule applied to whole packets.
// Time slots inside each 10 ns cycle: posedge, +1 requester/monitor,
// +2 UART model, +3 test tasks.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;

    typedef struct {
        logic [7:0] b;
        bit         last;
        int         gap;   // cycles to drop req after this byte's ack
    } entry_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   last = '0;
    logic [8*NREQ-1:0] data = '0;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              uart_txen;
    logic [7:0]        uart_din;
    logic              uart_txready = 1'b1;

    uart_tx_arbiter #(.NREQ(NREQ), .IDXW(2)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req          (req),
        .last         (last),
        .data         (data),
        .ack          (ack),
        .grant        (grant),
        .busy         (busy),
        .uart_txen    (uart_txen),
        .uart_din     (uart_din),
        .uart_txready (uart_txready)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    entry_t      rq [NREQ][$];
    int          gap_cnt [NREQ];
    int          ack_cnt [NREQ];
    logic [11:0] exp_q [$];
    bit          sb_en = 1'b0;

    // UART model state
    int byte_cycles = 12;
    bit rand_bytes = 1'b0;
    int u_cnt = 0;
    bit u_pend = 1'b0;
    int rise_cyc = 0;

    // monitor state
    bit          in_pkt = 1'b0;
    int          prev_gap = 0;
    int          mon_k;
    logic [11:0] mon_exp;

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    // Behavioural UART
    initial forever begin
        @(posedge clock);
        #2;
        if (u_pend) begin
            uart_txready = 1'b0;
            u_cnt = rand_bytes ? int'($urandom_range(2, 14)) : byte_cycles;
            u_pend = 1'b0;
        end else if (!uart_txready) begin
            if (u_cnt <= 1) begin
                uart_txready = 1'b1;
                rise_cyc = cyc;
            end else begin
                u_cnt = u_cnt - 1;
            end
        end
        if (uart_txen) u_pend = 1'b1;
    end

    // Monitor + requester driver
    initial forever begin
        @(posedge clock);
        #1;
        if (!reset_n) in_pkt = 1'b0;
        if (uart_txen) begin
            mon_k = -1;
            for (int i = 0; i < NREQ; i++) if (ack[i]) mon_k = i;
            $display("tx cyc=%0d owner=%0d byte=%02h", cyc, mon_k, uart_din);
            checks++;
            if (uart_txready !== 1'b1) begin
                failures++;
                $display("FAIL txen_gate: uart_txready=%b required 1 at load", uart_txready);
            end
            checks++;
            if (mon_k < 0 || $countones(ack) != 1 || grant !== ack || busy !== 1'b1) begin
                failures++;
                $display("FAIL ack_grant: ack=%b grant=%b busy=%b required one-hot ack==grant, busy=1",
                         ack, grant, busy);
            end
            if (mon_k >= 0 && sb_en && rq[mon_k].size() > 0) begin
                if (in_pkt && prev_gap == 0) begin
                    checks++;
                    if (cyc != rise_cyc + 1) begin
                        failures++;
                        $display("FAIL byte_latency: txready-rise to txen=%0d cycles required 1",
                                 cyc - rise_cyc);
                    end
                end
                checks++;
                mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
                if ({4'(mon_k), uart_din} !== mon_exp) begin
                    failures++;
                    $display("FAIL sequence: got owner=%0d byte=%02h required owner=%0d byte=%02h",
                             mon_k, uart_din, mon_exp[11:8], mon_exp[7:0]);
                end
                in_pkt   = !rq[mon_k][0].last;
                prev_gap = rq[mon_k][0].gap;
            end
            if (mon_k >= 0) ack_cnt[mon_k]++;
        end else begin
            checks++;
            if (ack !== '0 || busy !== (grant != '0)) begin
                failures++;
                $display("FAIL idle_outputs: ack=%b busy=%b grant=%b required ack=0 busy=|grant",
                         ack, busy, grant);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i] && rq[i].size() > 0) begin
                gap_cnt[i] = rq[i][0].gap;
                void'(rq[i].pop_front());
            end else if (gap_cnt[i] > 0) begin
                gap_cnt[i] = gap_cnt[i] - 1;
            end
            req[i]         = (rq[i].size() > 0) && (gap_cnt[i] == 0);
            data[i*8 +: 8] = (rq[i].size() > 0) ? rq[i][0].b : 8'h00;
            last[i]        = (rq[i].size() > 0) ? rq[i][0].last : 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #3;
        end
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) e = 1'b0;
        return e;
    endfunction

    function automatic void flush();
        for (int i = 0; i < NREQ; i++) begin
            rq[i].delete();
            gap_cnt[i] = 0;
            ack_cnt[i] = 0;
        end
        exp_q.delete();
    endfunction

    function automatic void push_pkt(input int k, input logic [7:0] b, input bit l, input int g);
        entry_t e;
        e.b = b;
        e.last = l;
        e.gap = g;
        rq[k].push_back(e);
    endfunction

    // Whole-packet round-robin from pointer 0, assuming every queued
    // requester is asserting req whenever the UART is free.
    function automatic void predict();
        entry_t t [NREQ][$];
        entry_t e;
        int p;
        int k;
        int c;
        for (int j = 0; j < NREQ; j++) t[j] = rq[j];
        exp_q.delete();
        p = 0;
        while (1) begin
            k = -1;
            for (int j = 0; j < NREQ; j++) begin
                c = (p + j) % NREQ;
                if (k < 0 && t[c].size() > 0) k = c;
            end
            if (k < 0) break;
            while (t[k].size() > 0) begin
                e = t[k].pop_front();
                exp_q.push_back({4'(k), e.b});
                if (e.last) break;
            end
            p = (k + 1) % NREQ;
        end
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        flush();
        tick(2);
        reset_n = 1'b1;
        for (int i = 0; i < 400 && !uart_txready; i++) tick(1);
        tick(1);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (all_empty() && !busy && uart_txready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if (grant !== '0 || ack !== '0) begin
            failures++;
            $display("FAIL reset_grant_ack: grant=%b ack=%b required 0", grant, ack);
        end
        checks++;
        if (busy !== 1'b0 || uart_txen !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy_txen: busy=%b txen=%b required 0", busy, uart_txen);
        end
        checks++;
        if (uart_din !== 8'h00) begin
            failures++;
            $display("FAIL reset_din: din=%02h required 00", uart_din);
        end
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_single_byte();
        bit ok;
        apply_reset();
        sb_en = 1'b1;
        push_pkt(0, 8'hA5, 1'b1, 0);
        predict();
        tick(1);
        checks++;
        if (uart_txen !== 1'b0) begin
            failures++;
            $display("FAIL arb_early: txen=%b required 0 in the cycle req is first seen", uart_txen);
        end
        tick(1);
        checks++;
        if (uart_txen !== 1'b1 || ack !== 4'b0001 || grant !== 4'b0001 || uart_din !== 8'hA5) begin
            failures++;
            $display("FAIL arb_latency: txen=%b ack=%b grant=%b din=%02h required 1 0001 0001 A5",
                     uart_txen, ack, grant, uart_din);
        end
        wait_done(400, ok);
        checks++;
        if (!ok || ack_cnt[0] != 1 || grant !== '0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_byte: done=%b acks=%0d grant=%b pending=%0d required 1 1 0000 0",
                     ok, ack_cnt[0], grant, exp_q.size());
        end
        // ptr is now 1: with 0 and 1 both requesting, 1 goes first.
        push_pkt(0, 8'h5A, 1'b1, 0);
        push_pkt(1, 8'h6B, 1'b1, 0);
        exp_q.push_back(12'h16B);
        exp_q.push_back(12'h05A);
        wait_done(600, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            failures++;
            $display("FAIL ptr_after_pkt: done=%b pending=%0d required 1 0", ok, exp_q.size());
        end
    endtask

    task automatic test_atomicity();
        bit ok;
        int l;
        apply_reset();
        push_pkt(0, 8'h11, 1'b0, 0);
        push_pkt(0, 8'h22, 1'b0, 0);
        push_pkt(0, 8'h33, 1'b1, 0);
        push_pkt(2, 8'h99, 1'b1, 0);
        predict();
        for (int i = 0; i < 600 && !(uart_txen && uart_din == 8'h33); i++) tick(1);
        checks++;
        if (!(uart_txen && uart_din == 8'h33)) begin
            failures++;
            $display("FAIL atomic_wait: byte 33 load not seen, din=%02h required 33", uart_din);
        end
        l = cyc;
        for (int i = 0; i < 200 && !(rise_cyc > l); i++) begin
            checks++;
            if (grant[2] !== 1'b0) begin
                failures++;
                $display("FAIL atomic_grant: grant=%b required grant[2]=0 before 33 completes", grant);
            end
            tick(1);
        end
        wait_done(600, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            failures++;
            $display("FAIL atomicity: done=%b pending=%0d required 1 0", ok, exp_q.size());
        end
    endtask

    task automatic test_fairness();
        bit ok;
        apply_reset();
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < NREQ; k++) push_pkt(k, 8'h10 + 8'(k), 1'b1, 0);
        predict();
        wait_done(2000, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            failures++;
            $display("FAIL fairness_order: done=%b pending=%0d required 1 0", ok, exp_q.size());
        end
        for (int k = 0; k < NREQ; k++) begin
            checks++;
            if (ack_cnt[k] != 3) begin
                failures++;
                $display("FAIL fairness_acks: requester %0d acks=%0d required 3", k, ack_cnt[k]);
            end
        end
    endtask

    task automatic test_hold();
        bit ok;
        apply_reset();
        push_pkt(1, 8'h40, 1'b0, 50);
        push_pkt(1, 8'h41, 1'b1, 0);
        push_pkt(3, 8'h77, 1'b1, 0);
        predict();
        for (int i = 0; i < 300 && !(uart_txen && uart_din == 8'h40); i++) tick(1);
        checks++;
        if (!(uart_txen && uart_din == 8'h40)) begin
            failures++;
            $display("FAIL hold_wait: byte 40 load not seen, din=%02h required 40", uart_din);
        end
        for (int j = 1; j < 50; j++) begin
            tick(1);
            checks++;
            if (grant !== 4'b0010 || busy !== 1'b1 || uart_txen !== 1'b0) begin
                failures++;
                $display("FAIL hold_state: cycle %0d grant=%b busy=%b txen=%b required 0010 1 0",
                         j, grant, busy, uart_txen);
            end
        end
        tick(1);
        checks++;
        if (uart_txen !== 1'b0) begin
            failures++;
            $display("FAIL hold_reassert_early: txen=%b required 0", uart_txen);
        end
        tick(1);
        checks++;
        if (uart_txen !== 1'b1 || uart_din !== 8'h41 || grant !== 4'b0010) begin
            failures++;
            $display("FAIL hold_reassert: txen=%b din=%02h grant=%b required 1 41 0010",
                     uart_txen, uart_din, grant);
        end
        wait_done(600, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            failures++;
            $display("FAIL hold_done: done=%b pending=%0d required 1 0", ok, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int r0;
        apply_reset();
        byte_cycles = 20;
        push_pkt(0, 8'hC1, 1'b0, 0);
        push_pkt(0, 8'hC2, 1'b0, 0);
        push_pkt(0, 8'hC3, 1'b1, 0);
        predict();
        for (int i = 0; i < 400 && ack_cnt[0] < 2; i++) tick(1);
        for (int i = 0; i < 50 && uart_txready; i++) tick(1);
        tick(3);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({grant, ack, busy, uart_txen, uart_din} !== '0) begin
            failures++;
            $display("FAIL reset_mid: grant=%b ack=%b busy=%b txen=%b din=%02h required all 0",
                     grant, ack, busy, uart_txen, uart_din);
        end
        flush();
        push_pkt(1, 8'h77, 1'b1, 0);
        exp_q.push_back(12'h177);
        r0 = rise_cyc;
        tick(1);
        reset_n = 1'b1;
        for (int i = 0; i < 200 && !uart_txen; i++) tick(1);
        checks++;
        if (uart_txen !== 1'b1 || rise_cyc == r0 || grant !== 4'b0010) begin
            failures++;
            $display("FAIL reset_reload: txen=%b txready_rose=%b grant=%b required 1 1 0010",
                     uart_txen, rise_cyc != r0, grant);
        end
        wait_done(400, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            failures++;
            $display("FAIL reset_done: done=%b pending=%0d required 1 0", ok, exp_q.size());
        end
        byte_cycles = 12;
    endtask

    task automatic test_random();
        bit ok;
        int npk;
        int len;
        rand_bytes = 1'b1;
        for (int round = 0; round < 4; round++) begin
            apply_reset();
            for (int k = 0; k < NREQ; k++) begin
                npk = int'($urandom_range(0, 3));
                for (int p = 0; p < npk; p++) begin
                    len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++) begin
                        push_pkt(k, 8'($urandom), b == len - 1,
                                 (b != len - 1 && $urandom_range(0, 3) == 0)
                                     ? int'($urandom_range(1, 15)) : 0);
                    end
                end
            end
            predict();
            wait_done(5000, ok);
            checks++;
            if (!ok || exp_q.size() != 0) begin
                failures++;
                $display("FAIL random_round%0d: done=%b pending=%0d required 1 0",
                         round, ok, exp_q.size());
            end
        end
        rand_bytes = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            gap_cnt[i] = 0;
            ack_cnt[i] = 0;
        end
        test_reset();
        sb_en = 1'b1;
        test_single_byte();
        test_atomicity();
        test_fairness();
        test_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
